// File: rtl/ir_xmit.sv
// NEC infrared transmitter: 16-bit {addr, cmd} code sent as a 38 kHz-modulated frame on ir_tx.
// Repeat codes while `hold` is asserted are compiled in only with IR_XMIT_REPEAT_EN defined.
module ir_xmit #(
    parameter int UNIT_CYC    = 15188,
    parameter int CARRIER_CYC = 711,
    parameter int CARRIER_HI  = 237
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic [15:0] code,
    input  logic        send_req,
    input  logic        hold,
    output logic        ir_tx,
    output logic        ir_env,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_cnt
);

    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int CW = (CARRIER_CYC > 1) ? $clog2(CARRIER_CYC) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
`ifdef IR_XMIT_REPEAT_EN
        ,
        REP_MARK,
        REP_SPACE,
        REP_STOP
`endif
    } state_t;

    state_t          state;
    logic [UW-1:0]   unit_cnt;
    logic [7:0]      frame_t;
    logic [3:0]      unit_left;
    logic [4:0]      bit_idx;
    logic [31:0]     payload;
    logic [CW-1:0]   car_ph;
    logic [CW-1:0]   car_nxt;
    logic            car_hi_nxt;
    logic            unit_tick;

`ifndef IR_XMIT_REPEAT_EN
    logic unused_hold;
    assign unused_hold = hold;
`endif

    assign unit_tick = (state != IDLE) && (unit_cnt == UNIT_LAST);

    always_comb begin
        car_nxt    = (car_ph == CAR_LAST) ? '0 : car_ph + 1'b1;
        car_hi_nxt = (int'(car_nxt) < CARRIER_HI);
    end

    // Per-state timing counts down remaining units; the case below overrides
    // the reload and the envelope/carrier on the tick that ends a state.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            unit_cnt  <= '0;
            frame_t   <= '0;
            unit_left <= '0;
            bit_idx   <= '0;
            payload   <= '0;
            car_ph    <= '0;
            ir_tx     <= 1'b0;
            ir_env    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE)
                unit_cnt <= unit_tick ? '0 : unit_cnt + 1'b1;
            if (unit_tick && frame_t != 8'd192)
                frame_t <= frame_t + 8'd1;
            if (unit_tick && unit_left != '0)
                unit_left <= unit_left - 4'd1;
            if (ir_env) begin
                car_ph <= car_nxt;
                ir_tx  <= car_hi_nxt;
            end

            case (state)
                IDLE: begin
                    if (send_req) begin
                        payload   <= {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
                        unit_cnt  <= '0;
                        frame_t   <= '0;
                        bit_idx   <= '0;
                        unit_left <= 4'd15;
                        busy      <= 1'b1;
                        car_ph    <= '0;
                        ir_env    <= 1'b1;
                        ir_tx     <= (CARRIER_HI > 0);
                        state     <= LEAD_MARK;
                    end
                end
                LEAD_MARK: begin
                    if (unit_tick && unit_left == '0) begin
                        unit_left <= 4'd7;
                        ir_env    <= 1'b0;
                        ir_tx     <= 1'b0;
                        state     <= LEAD_SPACE;
                    end
                end
                LEAD_SPACE: begin
                    if (unit_tick && unit_left == '0) begin
                        unit_left <= 4'd0;
                        car_ph    <= '0;
                        ir_env    <= 1'b1;
                        ir_tx     <= (CARRIER_HI > 0);
                        state     <= BIT_MARK;
                    end
                end
                BIT_MARK: begin
                    if (unit_tick && unit_left == '0) begin
                        unit_left <= payload[0] ? 4'd2 : 4'd0;
                        ir_env    <= 1'b0;
                        ir_tx     <= 1'b0;
                        state     <= BIT_SPACE;
                    end
                end
                BIT_SPACE: begin
                    if (unit_tick && unit_left == '0) begin
                        unit_left <= 4'd0;
                        car_ph    <= '0;
                        ir_env    <= 1'b1;
                        ir_tx     <= (CARRIER_HI > 0);
                        if (bit_idx == 5'd31) begin
                            state <= STOP_MARK;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            payload <= {1'b0, payload[31:1]};
                            state   <= BIT_MARK;
                        end
                    end
                end
                STOP_MARK: begin
                    if (unit_tick && unit_left == '0) begin
                        tx_cnt <= tx_cnt + 8'd1;
                        ir_env <= 1'b0;
                        ir_tx  <= 1'b0;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (unit_tick && frame_t == 8'd191) begin
`ifdef IR_XMIT_REPEAT_EN
                        if (hold) begin
                            frame_t   <= '0;
                            unit_left <= 4'd15;
                            car_ph    <= '0;
                            ir_env    <= 1'b1;
                            ir_tx     <= (CARRIER_HI > 0);
                            state     <= REP_MARK;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
`endif
                    end
                end
`ifdef IR_XMIT_REPEAT_EN
                REP_MARK: begin
                    if (unit_tick && unit_left == '0) begin
                        unit_left <= 4'd3;
                        ir_env    <= 1'b0;
                        ir_tx     <= 1'b0;
                        state     <= REP_SPACE;
                    end
                end
                REP_SPACE: begin
                    if (unit_tick && unit_left == '0) begin
                        unit_left <= 4'd0;
                        car_ph    <= '0;
                        ir_env    <= 1'b1;
                        ir_tx     <= (CARRIER_HI > 0);
                        state     <= REP_STOP;
                    end
                end
                REP_STOP: begin
                    if (unit_tick && unit_left == '0) begin
                        ir_env <= 1'b0;
                        ir_tx  <= 1'b0;
                        state  <= GAP;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_xmit.sv
// Bench for ir_xmit: random codes checked cycle by cycle against a unit-level NEC timing model.
module tb_ir_xmit;

    localparam int UNIT = 20;
    localparam int CYC  = 6;
    localparam int HI   = 2;
    localparam int BURST = 192 * UNIT;

    logic        clk27 = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] code = '0;
    logic        send_req = 1'b0;
    logic        hold = 1'b0;
    logic        ir_tx, ir_env, busy, done;
    logic [7:0]  tx_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_cnt = '0;
    bit          env_trace[$];

    ir_xmit #(.UNIT_CYC(UNIT), .CARRIER_CYC(CYC), .CARRIER_HI(HI)) dut (
        .clk27(clk27), .reset_n(reset_n), .code(code), .send_req(send_req),
        .hold(hold), .ir_tx(ir_tx), .ir_env(ir_env), .busy(busy), .done(done),
        .tx_cnt(tx_cnt)
    );

    always #5 clk27 = ~clk27;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start unit of the mark covering unit u of a burst, or -1 if u is in a space/gap.
    function automatic int mark_start_unit(input logic [15:0] c, input bit rep, input int u);
        logic [31:0] p;
        int pos;
        if (u < 16) return 0;
        if (rep) return (u == 20) ? 20 : -1;
        if (u < 24) return -1;
        p = {~c[7:0], c[7:0], ~c[15:8], c[15:8]};
        pos = 24;
        for (int i = 0; i < 32; i++) begin
            if (u == pos) return pos;
            pos += 1 + (p[i] ? 3 : 1);
            if (u < pos) return -1;
        end
        return (u == pos) ? pos : -1;
    endfunction

    task automatic check_burst(input bit rep, input logic [15:0] c, input int inject_at, input int hold_drop_at);
        int ms;
        bit e_env, e_tx;
        for (int k = 0; k < BURST; k++) begin
            ms = mark_start_unit(c, rep, k / UNIT);
            e_env = (ms >= 0);
            e_tx  = e_env && (((k - ms * UNIT) % CYC) < HI);
            if (!rep && k == 121 * UNIT) exp_cnt++;
            check_val($sformatf("env@%0d", k), ir_env, e_env);
            check_val($sformatf("tx@%0d", k), ir_tx, e_tx);
            check_val($sformatf("busy@%0d", k), busy, 1);
            check_val($sformatf("done@%0d", k), done, 0);
            check_val($sformatf("tx_cnt@%0d", k), tx_cnt, exp_cnt);
            if (!rep) env_trace.push_back(ir_env);
            code = 16'($urandom);
            if (k == inject_at) begin
                code = 16'hFFFF;
                send_req = 1'b1;
            end else begin
                send_req = 1'b0;
            end
            if (k == hold_drop_at) hold = 1'b0;
            @(posedge clk27); #1;
        end
    endtask

    // Ends in the cycle after GAP, where done must be high.
    task automatic send_frame(input logic [15:0] c, input int inject_at);
        code = c;
        send_req = 1'b1;
        env_trace.delete();
        @(posedge clk27); #1;
        send_req = 1'b0;
        check_burst(0, c, inject_at, -1);
    endtask

    task automatic expect_done_cycle(input string tag);
        check_val({tag, "_done"}, done, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_env"}, ir_env, 0);
        check_val({tag, "_cnt"}, tx_cnt, exp_cnt);
    endtask

    task automatic idle_step(input string tag);
        send_req = 1'b0;
        @(posedge clk27); #1;
        check_val({tag, "_done_low"}, done, 0);
        check_val({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic decode_trace(input logic [31:0] exp_payload);
        int runs[$];
        int len;
        int last_hi;
        logic [31:0] data;
        len = 0;
        last_hi = -1;
        for (int i = 0; i < env_trace.size(); i++) begin
            if (env_trace[i]) last_hi = i;
            if (i > 0 && env_trace[i] != env_trace[i-1]) begin
                runs.push_back(len);
                len = 0;
            end
            len++;
        end
        runs.push_back(len);
        check_val("run_count", runs.size(), 68);
        check_val("env_end", last_hi, 2419);
        if (runs.size() == 68) begin
            check_val("lead_mark", runs[0], 16 * UNIT);
            check_val("lead_space", runs[1], 8 * UNIT);
            data = '0;
            for (int i = 0; i < 32; i++)
                data[i] = (runs[3 + 2 * i] > 2 * UNIT);
            check_val("payload", data, exp_payload);
        end
    endtask

    initial begin
        logic [15:0] c;

        #2 reset_n = 1'b0;
        #10 reset_n = 1'b1;
        @(posedge clk27); #1;
        check_val("por_env", ir_env, 0);
        check_val("por_tx", ir_tx, 0);
        check_val("por_busy", busy, 0);
        check_val("por_done", done, 0);
        check_val("por_cnt", tx_cnt, 0);

        // Reference frame: bytes 04 FB 1A E5 on the wire.
        send_frame(16'h041A, -1);
        expect_done_cycle("frame_041a");
        decode_trace(32'hE51AFB04);
        idle_step("frame_041a");

        // Asynchronous reset in the middle of LEAD_MARK.
        code = 16'($urandom);
        send_req = 1'b1;
        @(posedge clk27); #1;
        send_req = 1'b0;
        repeat (100) @(posedge clk27);
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_env", ir_env, 0);
        check_val("rst_tx", ir_tx, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cnt", tx_cnt, 0);
        exp_cnt = '0;
        #3 reset_n = 1'b1;
        repeat (3) @(posedge clk27);
        #1;
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_env", ir_env, 0);
        check_val("post_rst_cnt", tx_cnt, 0);

        // Back-to-back random frames, each new request issued in the done cycle.
        for (int f = 0; f < 3; f++) begin
            c = 16'($urandom);
            send_frame(c, -1);
            expect_done_cycle($sformatf("rand%0d", f));
        end
        idle_step("rand");

        // Request during busy must be dropped.
        c = 16'($urandom);
        send_frame(c, 1000);
        expect_done_cycle("busy_rej");
        idle_step("busy_rej");

        // Held key: hold dropped at cycle 5000 from frame start.
        hold = 1'b1;
        c = 16'($urandom);
        send_frame(c, -1);
`ifdef IR_XMIT_REPEAT_EN
        check_val("rep_start_done", done, 0);
        check_burst(1, c, -1, 5000 - BURST);
        expect_done_cycle("rep_end");
`else
        expect_done_cycle("norep_end");
        for (int k = 0; k <= BURST; k++) begin
            if (k > 0) check_val($sformatf("norep_done@%0d", k), done, 0);
            check_val($sformatf("norep_env@%0d", k), ir_env, 0);
            check_val($sformatf("norep_busy@%0d", k), busy, 0);
            if (k == 5000 - BURST) hold = 1'b0;
            @(posedge clk27); #1;
        end
`endif
        hold = 1'b0;
        idle_step("final");
        check_val("final_cnt", tx_cnt, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
